// File: rtl/cpu_gen2_if.sv
// Memory bus between the cpu_gen2 core (master) and its memory (slave).
// One request/ready handshake carries both reads and writes.
interface cpu_gen2_if #(
  parameter int DW = 8,
  parameter int AW = 16
) ();
  logic [AW-1:0] addr_bus;
  logic          mem_req;
  logic          mem_rdy;
  logic          data_write;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] wr_data;

  modport master (
    output addr_bus, mem_req, data_write, wr_data,
    input  mem_rdy, rd_data
  );

  modport slave (
    input  addr_bus, mem_req, data_write, wr_data,
    output mem_rdy, rd_data
  );
endinterface

// File: rtl/cpu_gen2.sv
// cpu_gen2: small accumulator CPU with a 6502-flavoured opcode subset,
// a handshaked memory bus and an internal return/data stack.
// Faults (undefined opcode, stack overflow/underflow) park the core in HALT.
module cpu_gen2 #(
  parameter int            DW          = 8,
  parameter int            AW          = 16,
  parameter int            STACK_DEPTH = 8,
  parameter logic [AW-1:0] RESET_PC    = '0
) (
  input  logic                           CLK,
  input  logic                           R,
  cpu_gen2_if.master                     bus,
  output logic [AW-1:0]                  pc_out,
  output logic [DW-1:0]                  reg_a,
  output logic [3:0]                     reg_p,
  output logic [2:0]                     curr_st,
  output logic [$clog2(STACK_DEPTH):0]   sp,
  output logic                           halted,
  output logic [1:0]                     fault
);
  localparam int IW  = $clog2(STACK_DEPTH);
  localparam int SPW = IW + 1;
  localparam int DW1 = DW + 1;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    OPER_LO = 3'd1,
    OPER_HI = 3'd2,
    MEM_RD  = 3'd3,
    MEM_WR  = 3'd4,
    EXEC    = 3'd5,
    HALT    = 3'd6
  } st_e;

  localparam logic [7:0] OP_LDA_I = 8'hA9, OP_ADC = 8'h69, OP_SBC = 8'hE9;
  localparam logic [7:0] OP_AND   = 8'h29, OP_ORA = 8'h09, OP_EOR = 8'h49;
  localparam logic [7:0] OP_LDA_A = 8'hAD, OP_STA = 8'h8D;
  localparam logic [7:0] OP_JMP   = 8'h4C, OP_JSR = 8'h20, OP_RTS = 8'h60;
  localparam logic [7:0] OP_PHA   = 8'h48, OP_PLA = 8'h68;
  localparam logic [7:0] OP_BEQ   = 8'hF0, OP_BNE = 8'hD0;
  localparam logic [7:0] OP_BCS   = 8'hB0, OP_BCC = 8'h90;
  localparam logic [7:0] OP_CLC   = 8'h18, OP_SEC = 8'h38, OP_NOP = 8'hEA;

  // architectural and bus registers (p = {N,V,Z,C})
  st_e           st, st_n;
  logic [AW-1:0] pc, pc_n, addr_q, addr_n;
  logic [DW-1:0] a, a_n, lo, lo_n, wr_q, wr_n;
  logic [3:0]    p, p_n;
  logic [SPW-1:0] sp_q, sp_n;
  logic [7:0]    op, op_n;
  logic [1:0]    flt, flt_n;
  logic          hlt, hlt_n;

  // stack storage is never reset; only sp says what is valid
  logic [AW-1:0] stk [STACK_DEPTH];
  logic          push;
  logic [AW-1:0] push_val;

  // datapath helpers
  logic           hs;
  logic [7:0]     opc;
  logic [AW-1:0]  pc_inc, br_tgt, opnd, top;
  logic [DW-1:0]  m_op, lg_res;
  logic [DW:0]    sum;
  logic           vflag;
  logic [SPW-1:0] sp_m1;
  logic           sp_full, sp_empty;

  // bus requests are dropped the instant R rises so an in-flight access is abandoned
  assign bus.mem_req    = !R && (st inside {FETCH, OPER_LO, OPER_HI, MEM_RD, MEM_WR});
  assign bus.data_write = !R && (st == MEM_WR);
  assign bus.addr_bus   = addr_q;
  assign bus.wr_data    = wr_q;

  assign hs       = bus.mem_req && bus.mem_rdy;
  assign opc      = bus.rd_data[7:0];
  assign pc_inc   = pc + AW'(1);
  assign br_tgt   = pc_inc + {{(AW-DW){bus.rd_data[DW-1]}}, bus.rd_data};
  assign opnd     = AW'({bus.rd_data, lo});
  assign sp_m1    = sp_q - SPW'(1);
  assign top      = stk[sp_m1[IW-1:0]];
  assign sp_full  = (sp_q == SPW'(STACK_DEPTH));
  assign sp_empty = (sp_q == '0);

  assign pc_out  = pc;
  assign reg_a   = a;
  assign reg_p   = p;
  assign curr_st = st;
  assign sp      = sp_q;
  assign halted  = hlt;
  assign fault   = flt;

  // ALU: SBC is ADC of the inverted operand; V from operand/result sign mismatch
  always_comb begin
    m_op  = (op == OP_SBC) ? ~bus.rd_data : bus.rd_data;
    sum   = {1'b0, a} + {1'b0, m_op} + DW1'(p[0]);
    vflag = (a[DW-1] == m_op[DW-1]) && (sum[DW-1] != a[DW-1]);
    case (op)
      OP_AND:  lg_res = a & bus.rd_data;
      OP_ORA:  lg_res = a | bus.rd_data;
      OP_EOR:  lg_res = a ^ bus.rd_data;
      default: lg_res = bus.rd_data;
    endcase
  end

  // next-state and datapath decode; nothing moves without a handshake except EXEC
  always_comb begin
    st_n = st;  pc_n = pc;  a_n = a;  p_n = p;  sp_n = sp_q;  op_n = op;
    lo_n = lo;  flt_n = flt;  hlt_n = hlt;  wr_n = wr_q;  addr_n = addr_q;
    push = 1'b0;  push_val = '0;
    case (st)
      FETCH: if (hs) begin
        op_n = opc;
        pc_n = pc_inc;
        case (opc)
          OP_LDA_I, OP_ADC, OP_SBC, OP_AND, OP_ORA, OP_EOR,
          OP_LDA_A, OP_STA, OP_JMP, OP_JSR,
          OP_BEQ, OP_BNE, OP_BCS, OP_BCC:          st_n = OPER_LO;
          OP_RTS, OP_PHA, OP_PLA,
          OP_CLC, OP_SEC, OP_NOP:                  st_n = EXEC;
          default: begin
            st_n = HALT;  flt_n = 2'b01;  hlt_n = 1'b1;
          end
        endcase
      end
      OPER_LO: if (hs) begin
        lo_n = bus.rd_data;
        pc_n = pc_inc;
        st_n = FETCH;
        case (op)
          OP_LDA_I, OP_AND, OP_ORA, OP_EOR: begin
            a_n    = lg_res;
            p_n[3] = lg_res[DW-1];
            p_n[1] = (lg_res == '0);
          end
          OP_ADC, OP_SBC: begin
            a_n = sum[DW-1:0];
            p_n = {sum[DW-1], vflag, (sum[DW-1:0] == '0), sum[DW]};
          end
          OP_BEQ:  if (p[1])  pc_n = br_tgt;
          OP_BNE:  if (!p[1]) pc_n = br_tgt;
          OP_BCS:  if (p[0])  pc_n = br_tgt;
          OP_BCC:  if (!p[0]) pc_n = br_tgt;
          default: st_n = OPER_HI;
        endcase
      end
      OPER_HI: if (hs) begin
        pc_n = pc_inc;
        st_n = FETCH;
        case (op)
          OP_LDA_A: st_n = MEM_RD;
          OP_STA: begin
            st_n = MEM_WR;
            wr_n = a;
          end
          OP_JMP:   pc_n = opnd;
          OP_JSR: begin
            if (sp_full) begin
              pc_n = pc;  st_n = HALT;  flt_n = 2'b10;  hlt_n = 1'b1;
            end else begin
              push = 1'b1;  push_val = pc_inc;  sp_n = sp_q + SPW'(1);  pc_n = opnd;
            end
          end
          default: ;
        endcase
      end
      MEM_RD: if (hs) begin
        a_n    = bus.rd_data;
        p_n[3] = bus.rd_data[DW-1];
        p_n[1] = (bus.rd_data == '0);
        st_n   = FETCH;
      end
      MEM_WR: if (hs) st_n = FETCH;
      EXEC: begin
        st_n = FETCH;
        case (op)
          OP_RTS, OP_PLA: begin
            if (sp_empty) begin
              st_n = HALT;  flt_n = 2'b11;  hlt_n = 1'b1;
            end else begin
              sp_n = sp_m1;
              if (op == OP_RTS) pc_n = top;
              else begin
                a_n    = top[DW-1:0];
                p_n[3] = top[DW-1];
                p_n[1] = (top[DW-1:0] == '0);
              end
            end
          end
          OP_PHA: begin
            if (sp_full) begin
              st_n = HALT;  flt_n = 2'b10;  hlt_n = 1'b1;
            end else begin
              push = 1'b1;  push_val = {{(AW-DW){1'b0}}, a};  sp_n = sp_q + SPW'(1);
            end
          end
          OP_CLC:  p_n[0] = 1'b0;
          OP_SEC:  p_n[0] = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    // the address only changes when a step completes, so it is held across stalls
    if (hs || st == EXEC)
      addr_n = (st_n == MEM_RD || st_n == MEM_WR) ? opnd : pc_n;
  end

  // architectural state and registered bus outputs
  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      st     <= FETCH;
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
      a      <= '0;
      p      <= '0;
      sp_q   <= '0;
      op     <= '0;
      lo     <= '0;
      wr_q   <= '0;
      flt    <= '0;
      hlt    <= 1'b0;
    end else begin
      st     <= st_n;
      pc     <= pc_n;
      addr_q <= addr_n;
      a      <= a_n;
      p      <= p_n;
      sp_q   <= sp_n;
      op     <= op_n;
      lo     <= lo_n;
      wr_q   <= wr_n;
      flt    <= flt_n;
      hlt    <= hlt_n;
    end
  end

  // stack write port
  always_ff @(posedge CLK) begin
    if (push) stk[sp_q[IW-1:0]] <= push_val;
  end
endmodule

// File: tb/tb_cpu_gen2.sv
// Directed bench for cpu_gen2: three instances (default, 2-deep stack,
// 12/20-bit datapath) with behavioural memories and a write scoreboard.
module tb_cpu_gen2;
  logic CLK = 1'b0;
  logic R   = 1'b1;
  logic rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  cpu_gen2_if #(.DW(8),  .AW(16)) b0 ();
  cpu_gen2_if #(.DW(8),  .AW(16)) b1 ();
  cpu_gen2_if #(.DW(12), .AW(20)) b2 ();

  logic [7:0]  m0 [0:65535];
  logic [7:0]  m1 [0:15];
  logic [11:0] m2 [0:255];

  assign b0.rd_data = m0[b0.addr_bus];
  assign b0.mem_rdy = rdy0;
  assign b1.rd_data = m1[b1.addr_bus[3:0]];
  assign b1.mem_rdy = rdy1;
  assign b2.rd_data = m2[b2.addr_bus[7:0]];
  assign b2.mem_rdy = rdy2;

  logic [15:0] pc0;  logic [7:0]  a0;  logic [3:0] p0;  logic [2:0] st0;
  logic [3:0]  sp0;  logic h0;  logic [1:0] f0;
  logic [15:0] pc1;  logic [7:0]  a1;  logic [3:0] p1;  logic [2:0] st1;
  logic [1:0]  sp1;  logic h1;  logic [1:0] f1;
  logic [19:0] pc2;  logic [11:0] a2;  logic [3:0] p2;  logic [2:0] st2;
  logic [3:0]  sp2;  logic h2;  logic [1:0] f2;

  cpu_gen2 u0 (.CLK(CLK), .R(R), .bus(b0.master), .pc_out(pc0), .reg_a(a0), .reg_p(p0),
               .curr_st(st0), .sp(sp0), .halted(h0), .fault(f0));
  cpu_gen2 #(.STACK_DEPTH(2)) u1 (.CLK(CLK), .R(R), .bus(b1.master), .pc_out(pc1), .reg_a(a1),
               .reg_p(p1), .curr_st(st1), .sp(sp1), .halted(h1), .fault(f1));
  cpu_gen2 #(.DW(12), .AW(20), .RESET_PC(20'h00100)) u2 (.CLK(CLK), .R(R), .bus(b2.master),
               .pc_out(pc2), .reg_a(a2), .reg_p(p2), .curr_st(st2), .sp(sp2), .halted(h2),
               .fault(f2));

  typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t wq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clr0();
    for (int i = 0; i < 65536; i++) m0[i] = 8'h00;
  endtask

  // n bytes of b (most significant first) into m0 starting at base
  task automatic ld(input int base, input logic [63:0] b, input int n);
    for (int i = 0; i < n; i++) m0[16'(base + i)] = b[8*(n-1-i) +: 8];
  endtask

  // scoreboard: every accepted write on u0 must match the head of wq
  always @(negedge CLK) begin
    if (!R && b0.mem_req && b0.mem_rdy && b0.data_write) begin
      m0[b0.addr_bus] = b0.wr_data;
      if (wq.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
      else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", b0.addr_bus, e.a);
        chk("wr_data", b0.wr_data, e.d);
      end
    end
  end

  initial begin
    clr0();
    for (int i = 0; i < 16; i++)  m1[i] = 8'h48;
    for (int i = 0; i < 256; i++) m2[i] = 12'h000;

    // ---- ALU sequence, reset values, STA, undefined opcode
    ld(16'h0000, 64'hA9_05_69_FB_69_7F_8D_00, 8);
    ld(16'h0008, 64'h20_E9_01_29_0F_49_0E_09, 8);
    ld(16'h0010, 64'hF0_18_38_EA_02, 5);
    wq.push_back('{16'h2000, 8'h80});
    tick(1);
    chk("rst_st", st0, 0);       chk("rst_pc", pc0, 0);       chk("rst_a", a0, 0);
    chk("rst_p", p0, 0);         chk("rst_sp", sp0, 0);       chk("rst_halted", h0, 0);
    chk("rst_fault", f0, 0);     chk("rst_req", b0.mem_req, 0);
    chk("rst_we", b0.data_write, 0);  chk("rst_addr", b0.addr_bus, 0);
    chk("rst_wd", b0.wr_data, 0);
    chk("rst_addr_u2", b2.addr_bus, 20'h00100);
    R = 1'b0;
    tick(4);  chk("adc_fb_a", a0, 8'h00);  chk("adc_fb_p", p0, 4'h3);  chk("adc_fb_pc", pc0, 16'h0004);
    tick(2);  chk("adc_7f_a", a0, 8'h80);  chk("adc_7f_p", p0, 4'hC);
    tick(4);  chk("sta_pc", pc0, 16'h0009);  chk("sta_mem", m0[16'h2000], 8'h80);
    chk("wr_pending", wq.size(), 0);
    tick(2);  chk("sbc_a", a0, 8'h7E);  chk("sbc_p", p0, 4'h5);
    tick(2);  chk("and_a", a0, 8'h0E);  chk("and_p", p0, 4'h5);
    tick(2);  chk("eor_a", a0, 8'h00);  chk("eor_p", p0, 4'h7);
    tick(2);  chk("ora_a", a0, 8'hF0);  chk("ora_p", p0, 4'hD);
    tick(2);  chk("clc_p", p0, 4'hC);
    tick(2);  chk("sec_p", p0, 4'hD);
    tick(2);  chk("nop_pc", pc0, 16'h0014);  chk("nop_st", st0, 0);
    tick(1);  chk("undef_halted", h0, 1);  chk("undef_fault", f0, 2'b01);
    chk("undef_st", st0, 6);  chk("undef_req", b0.mem_req, 0);  chk("undef_pc", pc0, 16'h0015);
    tick(2);  chk("halt_stays", st0, 6);  chk("halt_req", b0.mem_req, 0);

    // ---- LDA abs with a stalled MEM_RD
    R = 1'b1;  clr0();  ld(16'h0000, 64'hAD_34_12, 3);  m0[16'h1234] = 8'h80;
    tick(1);  R = 1'b0;
    tick(3);  rdy0 = 1'b0;
    chk("ldabs_st", st0, 3);  chk("ldabs_req", b0.mem_req, 1);
    for (int i = 0; i < 3; i++) begin
      chk("ldabs_addr_hold", b0.addr_bus, 16'h1234);
      chk("ldabs_a_wait", a0, 8'h00);
      tick(1);
      chk("ldabs_st_wait", st0, 3);
    end
    chk("ldabs_addr_rdy", b0.addr_bus, 16'h1234);
    rdy0 = 1'b1;
    tick(1);  chk("ldabs_a", a0, 8'h80);  chk("ldabs_p", p0, 4'h8);
    chk("ldabs_st_done", st0, 0);  chk("ldabs_pc", pc0, 16'h0003);

    // ---- JSR / RTS
    R = 1'b1;  clr0();  ld(16'h0000, 64'h20_00_03_EA, 4);  m0[16'h0300] = 8'h60;
    tick(1);  R = 1'b0;
    chk("jsr_sp0", sp0, 0);
    tick(3);  chk("jsr_sp1", sp0, 1);  chk("jsr_pc", pc0, 16'h0300);
    tick(2);  chk("rts_sp0", sp0, 0);  chk("rts_pc", pc0, 16'h0003);  chk("rts_st", st0, 0);

    // ---- BEQ taken with Z=1
    R = 1'b1;  clr0();  ld(16'h0000, 64'hA9_00_4C_10_00, 5);  ld(16'h0010, 64'hF0_FC, 2);
    tick(1);  R = 1'b0;
    tick(7);  chk("beq_taken_pc", pc0, 16'h000E);

    // ---- BEQ not taken, BCS not taken, BCC taken, BNE backwards with wrap
    R = 1'b1;  clr0();  ld(16'h0000, 64'hA9_01_4C_10_00, 5);
    ld(16'h0010, 64'hF0_FC_B0_02_90_02, 6);  ld(16'h0018, 64'hD0_80, 2);
    tick(1);  R = 1'b0;
    tick(7);  chk("beq_not_pc", pc0, 16'h0012);
    tick(2);  chk("bcs_not_pc", pc0, 16'h0014);
    tick(2);  chk("bcc_taken_pc", pc0, 16'h0018);
    tick(2);  chk("bne_wrap_pc", pc0, 16'hFF9A);

    // ---- PHA / PLA and pop underflow
    R = 1'b1;  clr0();  ld(16'h0000, 64'hA9_5A_48_A9_00_68_68, 7);
    tick(1);  R = 1'b0;
    tick(2);  chk("pha_pre_a", a0, 8'h5A);
    tick(2);  chk("pha_sp", sp0, 1);  chk("pha_req_exec", b0.mem_req, 1);
    tick(2);  chk("lda0_p", p0, 4'h2);
    tick(2);  chk("pla_a", a0, 8'h5A);  chk("pla_sp", sp0, 0);  chk("pla_p", p0, 4'h0);
    tick(2);  chk("pop_empty_halted", h0, 1);  chk("pop_empty_fault", f0, 2'b11);
    chk("pop_empty_sp", sp0, 0);  chk("pop_empty_a", a0, 8'h5A);

    // ---- stack overflow on the 2-deep instance
    R = 1'b1;  tick(1);  R = 1'b0;
    tick(2);  chk("ovf_sp1", sp1, 1);
    tick(2);  chk("ovf_sp2", sp1, 2);
    tick(2);  chk("ovf_halted", h1, 1);  chk("ovf_fault", f1, 2'b10);
    chk("ovf_sp", sp1, 2);  chk("ovf_st", st1, 6);  chk("ovf_pc", pc1, 16'h0003);
    for (int i = 0; i < 3; i++) begin
      tick(1);  chk("ovf_req_low", b1.mem_req, 0);
    end

    // ---- 12/20-bit instance: wide operand, reset mid-MEM_WR, undefined 0xF02
    R = 1'b1;
    m2[0] = 12'h3A9;  m2[1] = 12'h876;  m2[2] = 12'h18D;  m2[3] = 12'h045;  m2[4] = 12'h123;
    tick(1);  R = 1'b0;
    tick(2);  chk("w_lda_a", a2, 12'h876);  chk("w_lda_p", p2, 4'h8);
    tick(3);  rdy2 = 1'b0;
    chk("w_sta_st", st2, 4);  chk("w_sta_we", b2.data_write, 1);
    chk("w_sta_wd", b2.wr_data, 12'h876);  chk("w_sta_addr", b2.addr_bus, 20'h23045);
    tick(1);  chk("w_sta_hold", b2.data_write, 1);
    R = 1'b1;  #1;
    chk("w_rst_we", b2.data_write, 0);  chk("w_rst_req", b2.mem_req, 0);  chk("w_rst_st", st2, 0);
    m2[0] = 12'hF02;
    tick(1);  chk("w_rst_addr", b2.addr_bus, 20'h00100);  chk("w_rst_pc", pc2, 20'h00100);
    R = 1'b0;  rdy2 = 1'b1;  #1;
    chk("w_first_req", b2.mem_req, 1);  chk("w_first_addr", b2.addr_bus, 20'h00100);
    tick(1);  chk("w_undef_fault", f2, 2'b01);  chk("w_undef_halted", h2, 1);
    chk("w_undef_pc", pc2, 20'h00101);

    chk("wr_pending_end", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
